// File: rtl/lc3_fetch_queue.sv
// ---------------------------------------------------------------------------
// lc3_fetch_queue
//
// LC3 fetch stage with a prefetch queue. Instruction-memory reads are issued
// ahead of Decode so fetching continues while Decode stalls. Each queue entry
// holds {instruction, npc}. A branch redirect flushes the queue and discards
// any response that is still in flight.
//
// Ports
//   clock, reset     single rising-edge clock, synchronous active-high reset
//   enable_fetch     gates the start of new memory requests
//   instrmem_rd, pc  memory request and its address (held until complete)
//   Instr_dout       instruction data, valid with complete_instr
//   complete_instr   memory response strobe (ignored while instrmem_rd=0)
//   br_taken, taddr  redirect pulse and target
//   deq_valid/ready  handshake towards Decode
//   deq_instr/npc    head entry of the queue
//   count            queue occupancy
//
// lc3_fetch_queue_chk holds the run-time property that the queue is never
// written while full.
// ---------------------------------------------------------------------------

module lc3_fetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clock,
  input logic          reset,
  input logic          push,
  input logic [CW-1:0] count
);

  // A write into a full queue would overwrite the head entry.
  no_overflow_a : assert property (@(posedge clock) disable iff (reset)
                                   push |-> (count != CW'(DEPTH)));

endmodule

module lc3_fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h3000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable_fetch,
  output logic                         instrmem_rd,
  output logic [ADDR_W-1:0]            pc,
  input  logic [DATA_W-1:0]            Instr_dout,
  input  logic                         complete_instr,
  input  logic                         br_taken,
  input  logic [ADDR_W-1:0]            taddr,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [DATA_W-1:0]            deq_instr,
  output logic [ADDR_W-1:0]            deq_npc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // WAIT: request outstanding, response will be enqueued.
  // DROP: request outstanding but a redirect arrived; the response is
  //       discarded and the saved target becomes the next pc.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [ADDR_W-1:0] tgt_r, tgt_nxt_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [PW-1:0]     head_r, tail_r;
  logic [CW-1:0]     count_r;
  logic [CW:0]       occ_after_s;
  logic              space_s;
  logic              push_s;
  logic              pop_s;
  logic              flush_s;

  logic [DATA_W-1:0] instr_mem_r [DEPTH];
  logic [ADDR_W-1:0] npc_mem_r   [DEPTH];

  // Pointer increment with explicit wrap, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_next = {PW{1'b0}};
    end else begin
      ptr_next = p + PW'(1);
    end
  endfunction

  assign pc_inc_s    = pc_r + ADDR_W'(1);
  assign pc          = pc_r;
  assign count       = count_r;
  assign instrmem_rd = (state_r != IDLE);
  assign deq_valid   = (count_r != {CW{1'b0}});
  assign deq_instr   = instr_mem_r[head_r];
  assign deq_npc     = npc_mem_r[head_r];
  assign pop_s       = deq_valid & deq_ready;
  // A redirect always empties the queue, whatever state the fetcher is in.
  assign flush_s     = br_taken;

  // Occupancy after this cycle's pop and the enqueue of the completing
  // response; a follow-on request is only issued if its response also fits.
  assign occ_after_s = {1'b0, count_r} - {{CW{1'b0}}, pop_s} + {{CW{1'b0}}, 1'b1};
  assign space_s     = (occ_after_s <= (CW + 1)'(DEPTH - 1));

  // Next-state, pc/target update and enqueue decision.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    tgt_nxt_s   = tgt_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (br_taken) begin
          pc_nxt_s = taddr;
        end else if (enable_fetch && (count_r < CW'(DEPTH))) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (complete_instr && br_taken) begin
          pc_nxt_s    = taddr;
          state_nxt_s = enable_fetch ? WAIT : IDLE;
        end else if (complete_instr) begin
          push_s      = 1'b1;
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = (enable_fetch && space_s) ? WAIT : IDLE;
        end else if (br_taken) begin
          // pc must stay stable until the memory answers.
          tgt_nxt_s   = taddr;
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DROP: begin
        if (complete_instr) begin
          pc_nxt_s    = br_taken ? taddr : tgt_r;
          state_nxt_s = enable_fetch ? WAIT : IDLE;
        end else if (br_taken) begin
          tgt_nxt_s   = taddr;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Fetch control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      tgt_r   <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      tgt_r   <= tgt_nxt_s;
    end
  end

  // Queue pointers and occupancy; a flush wins over a same-cycle pop.
  always_ff @(posedge clock) begin
    if (reset || flush_s) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= ptr_next(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_next(head_r);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Queue storage; entry contents need no reset since count gates validity.
  always_ff @(posedge clock) begin
    if (push_s) begin
      instr_mem_r[tail_r] <= Instr_dout;
      npc_mem_r[tail_r]   <= pc_inc_s;
    end
  end

  lc3_fetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .count (count_r)
  );

endmodule
